sr_cmd_driver: RTL and testbench
================================

Name: sr_cmd_driver

Overview:
- Upstream driver for the team's cross-coupled NAND SR latch. It converts clocked set/clear commands into properly timed active-low sbar/rbar pulses.
- Guarantees the latch never sees sbar=rbar=0, which is the forbidden state where q=qbar=1.
- Enforces a release gap between pulses, then samples the latch q output to confirm the write.
- Exposes a valid/ready command port plus done/error status to the controlling logic.

Parameters:
- PULSE_W, 4: cycles the selected active-low line is held low; legal range >=1.
- GAP_W, 2: cycles both lines are held high after a pulse, before q is checked; legal range >=1.
- CNT_W, 8: width of the internal timer; PULSE_W and GAP_W must each be <= 2^CNT_W.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  command present.
- req_op  input  1  1 = set (drive sbar low), 0 = clear (drive rbar low); sampled only on handshake.
- req_ready  output  1  block can accept a command.
- sbar  output  1  active-low set to latch; registered.
- rbar  output  1  active-low reset to latch; registered.
- q_fb  input  1  latch q output, fed back.
- busy  output  1  command in progress.
- done  output  1  one-cycle pulse when a command completes.
- err  output  1  valid only with done; 1 = q_fb did not match req_op.

Behaviour:
- Interface: one clock, clk; reset is synchronous, active-high, named reset.
- Reset values: sbar=1, rbar=1, req_ready=0 in the reset cycle then 1, busy=0, done=0, err=0, state=IDLE, timer=0. Reset overrides everything, including mid-pulse: a pulse in progress is truncated, both lines return high on the next edge, and the latch holds its value.
- FSM states: IDLE, PULSE, GAP, CHECK.
- IDLE:
  - req_ready=1, busy=0.
  - On req_valid && req_ready (cycle 0): capture op, load timer=PULSE_W-1, go to PULSE.
- PULSE:
  - Registered outputs drive the selected line low, starting the cycle after the handshake.
  - The line stays low for exactly PULSE_W cycles; the other line stays 1.
  - Timer counts down; at timer==0 go to GAP and load timer=GAP_W-1.
- GAP:
  - sbar=rbar=1 for exactly GAP_W cycles.
  - At timer==0 go to CHECK.
- CHECK:
  - One cycle: done=1, err=(q_fb != op).
  - Return to IDLE; req_ready=1 on the following cycle.
- busy=1 and req_ready=0 in PULSE, GAP and CHECK.
- Timeline for a handshake at cycle 0:
  - Pulse low during cycles 1..PULSE_W.
  - Gap during cycles PULSE_W+1..PULSE_W+GAP_W.
  - done at cycle PULSE_W+GAP_W+1.
  - Next handshake possible at cycle PULSE_W+GAP_W+2 at the earliest.
- req_valid while busy is ignored and not queued. req_op changes after the handshake have no effect.
- Invariant: sbar and rbar are never both 0 in any cycle, including across reset and back-to-back commands. The gap guarantees that an opposite command cannot overlap or abut the previous pulse.
- A repeated identical command, such as set while already set, is executed normally and reports err=0 if q_fb=1.
- q_fb is sampled only in CHECK and is don't-care elsewhere.
- Timer is CNT_W bits, unsigned, and never wraps in legal configurations.

Decomposition:
- Shared package/include: state encoding constants (ST_IDLE=0, ST_PULSE=1, ST_GAP=2, ST_CHECK=3) and op constants (OP_CLR=0, OP_SET=1), for reuse by future latch/flop drivers.
- One sub-module: pulse_timer, a loadable CNT_W down-counter with a zero flag, instantiated once. The FSM and output registers stay in sr_cmd_driver.

Test Plan (PULSE_W=4, GAP_W=2, latch model connected, q_fb=q):
- Reset released, no request: sbar=rbar=1, req_ready=1, done=0 for 10 cycles; latch holds its initial value.
- Set at cycle 0 (req_op=1): sbar=0 in cycles 1-4, both high in cycles 5-6, done=1 and err=0 at cycle 7, q=1; req_ready=1 at cycle 8.
- Clear issued immediately after a set completes: rbar=0 for 4 cycles; sbar and rbar are never both 0 (assertion every cycle); q goes to 0 and err=0.
- req_valid held high with alternating req_op while busy: exactly one command is accepted per PULSE_W+GAP_W+2 cycles, and the op sampled at each handshake is the one executed.
- Reset asserted at cycle 2 of a set pulse: sbar=1 on the next edge, busy=0, no done pulse; a new clear then completes normally.
- q_fb forced to 0 during a set: done=1 with err=1 at cycle 7; the next command is still accepted normally.

Source files
------------

// File: rtl/sr_cmd_driver_pkg.sv
// sr_cmd_driver_pkg
//   Shared constants for the latch/flop command drivers: FSM state encoding,
//   command op encoding, and a helper that maps (state, op) to the active-low
//   latch line levels.
package sr_cmd_driver_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2,
      ST_CHECK = 2'd3
   } state_e;

   localparam logic OP_CLR = 1'b0;
   localparam logic OP_SET = 1'b1;

   // Returns {sbar, rbar}. Only PULSE can pull a line low, and only one line
   // at a time, so the forbidden sbar=rbar=0 combination cannot be encoded.
   function automatic logic [1:0] line_levels(input state_e st, input logic op);
      logic [1:0] lv;
      lv = 2'b11;
      if (st == ST_PULSE) begin
         if (op == OP_SET) begin
            lv = 2'b01;
         end else begin
            lv = 2'b10;
         end
      end else begin
         lv = 2'b11;
      end
      return lv;
   endfunction

endpackage

// File: rtl/sr_cmd_driver_if.sv
// sr_cmd_driver_if
//   Command/latch bundle between a controller and sr_cmd_driver.
//   req_valid/req_op/req_ready : command handshake (op 1=set, 0=clear)
//   sbar/rbar                  : active-low lines to the NAND SR latch
//   q_fb                       : latch q fed back for write confirmation
//   busy/done/err              : status (err valid only with done)
//   slave  : the driver side; master : controller + latch side.
interface sr_cmd_driver_if;
   logic req_valid;
   logic req_op;
   logic req_ready;
   logic sbar;
   logic rbar;
   logic q_fb;
   logic busy;
   logic done;
   logic err;

   modport slave (
      input  req_valid, req_op, q_fb,
      output req_ready, sbar, rbar, busy, done, err
   );

   modport master (
      output req_valid, req_op, q_fb,
      input  req_ready, sbar, rbar, busy, done, err
   );
endinterface

// File: rtl/sr_cmd_driver_pulse_timer.sv
// pulse_timer
//   Loadable CNT_W-bit down-counter with a zero flag. Counts down one per
//   cycle and parks at zero; load takes priority over counting.
//   Ports: clk, reset (sync, active-high), load, load_val, zero.
import sr_cmd_driver_pkg::*;

module pulse_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: load, else decrement until zero, then hold.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - CNT_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/sr_cmd_driver.sv
// sr_cmd_driver
//   Turns set/clear commands into timed active-low sbar/rbar pulses for a
//   cross-coupled NAND SR latch: PULSE_W cycles low on the selected line,
//   GAP_W cycles with both lines high, then one CHECK cycle that compares
//   q_fb against the requested op and pulses done (err on mismatch).
//   Ports: clk, reset (sync, active-high), bus (sr_cmd_driver_if.slave).
import sr_cmd_driver_pkg::*;

module sr_cmd_driver #(
   parameter int unsigned PULSE_W = 4,
   parameter int unsigned GAP_W   = 2,
   parameter int unsigned CNT_W   = 8
) (
   input  logic            clk,
   input  logic            reset,
   sr_cmd_driver_if.slave  bus
);

   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_W - 1);

   state_e state_q, state_d;
   logic   op_q, op_d;
   logic   sbar_q, sbar_d;
   logic   rbar_q, rbar_d;
   logic   req_ready_q, req_ready_d;
   logic   busy_q, busy_d;
   logic   done_q, done_d;

   logic             tmr_load_s;
   logic [CNT_W-1:0] tmr_val_s;
   logic             tmr_zero_s;

   pulse_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load_s),
      .load_val (tmr_val_s),
      .zero     (tmr_zero_s)
   );

   // Next-state logic, timer loads, and next values of the registered outputs.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      tmr_load_s = 1'b0;
      tmr_val_s  = PULSE_LOAD;
      case (state_q)
         ST_IDLE: begin
            // req_ready_q is low in the reset cycle, so no capture there.
            if (bus.req_valid && req_ready_q) begin
               state_d    = ST_PULSE;
               op_d       = bus.req_op;
               tmr_load_s = 1'b1;
               tmr_val_s  = PULSE_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PULSE: begin
            if (tmr_zero_s) begin
               state_d    = ST_GAP;
               tmr_load_s = 1'b1;
               tmr_val_s  = GAP_LOAD;
            end else begin
               state_d = ST_PULSE;
            end
         end
         ST_GAP: begin
            if (tmr_zero_s) begin
               state_d = ST_CHECK;
            end else begin
               state_d = ST_GAP;
            end
         end
         ST_CHECK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they align with the state
      // register: the line drops the cycle after the handshake.
      {sbar_d, rbar_d} = line_levels(state_d, op_d);
      req_ready_d      = (state_d == ST_IDLE);
      busy_d           = (state_d != ST_IDLE);
      done_d           = (state_d == ST_CHECK);
   end

   // State, captured op and registered outputs; reset truncates any pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_CLR;
         sbar_q      <= 1'b1;
         rbar_q      <= 1'b1;
         req_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         sbar_q      <= sbar_d;
         rbar_q      <= rbar_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.sbar      = sbar_q;
   assign bus.rbar      = rbar_q;
   assign bus.req_ready = req_ready_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   // q_fb is only meaningful in CHECK, which is exactly when done_q is high.
   assign bus.err       = done_q & (bus.q_fb != op_q);

endmodule

// File: tb/tb_sr_cmd_driver.sv
// tb_sr_cmd_driver
//   Bench for sr_cmd_driver with a behavioural NAND SR latch on sbar/rbar.
//   Commands are table-driven; expected {op, err, q} records go to a
//   scoreboard queue at the handshake and are popped when done appears.
module tb_sr_cmd_driver;

   localparam int PW = 4;
   localparam int GW = 2;
   localparam int LAST = PW + GW + 1;   // phase of the done cycle

   logic clk = 1'b0;
   logic reset;
   logic force0;
   logic latch_q = 1'b0;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic op;
      logic err;
      logic q;
   } sb_t;
   sb_t sb_q[$];

   typedef struct packed {
      logic op;
      logic f0;
      logic exp_err;
      logic exp_q;
   } vec_t;
   vec_t vecs[6];

   sr_cmd_driver_if bus_if();

   sr_cmd_driver #(.PULSE_W(PW), .GAP_W(GW), .CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   // Behavioural NAND latch: low sbar sets, low rbar clears, both high hold.
   always @(bus_if.sbar or bus_if.rbar) begin
      if (bus_if.sbar === 1'b0 && bus_if.rbar === 1'b1) begin
         latch_q = 1'b1;
      end else if (bus_if.sbar === 1'b1 && bus_if.rbar === 1'b0) begin
         latch_q = 1'b0;
      end else begin
         latch_q = latch_q;
      end
   end

   assign bus_if.q_fb = force0 ? 1'b0 : latch_q;

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected {sbar,rbar,req_ready,busy,done} for phase k after a handshake
   // (k=0 means idle).
   task automatic expect_cycle(input int k, input logic op);
      logic       in_p;
      logic [4:0] e;
      logic [4:0] a;
      in_p = (k >= 1 && k <= PW);
      e = {!(in_p && op), !(in_p && !op), (k == 0), (k != 0), (k == LAST)};
      a = {bus_if.sbar, bus_if.rbar, bus_if.req_ready, bus_if.busy, bus_if.done};
      check_val($sformatf("phase%0d_op%0d_sbar_rbar_rdy_busy_done", k, op), 32'(a), 32'(e));
   endtask

   // One complete command, starting at the next negedge while idle.
   task automatic run_cmd(input logic op, input logic f0, input logic exp_err, input logic exp_q);
      sb_t s;
      @(negedge clk);
      expect_cycle(0, op);
      force0           = f0;
      bus_if.req_valid = 1'b1;
      bus_if.req_op    = op;
      s.op = op; s.err = exp_err; s.q = exp_q;
      sb_q.push_back(s);
      for (int k = 1; k <= LAST; k++) begin
         @(negedge clk);
         expect_cycle(k, op);
         if (k == 1) begin
            bus_if.req_valid = 1'b0;
            bus_if.req_op    = ~op;   // must not affect the running command
         end
      end
   endtask

   // Scoreboard consumer and per-cycle forbidden-state check.
   initial begin
      sb_t s;
      @(posedge clk);
      forever begin
         @(negedge clk);
         check_val("no_forbidden_state", 32'(bus_if.sbar | bus_if.rbar), 32'd1);
         if (bus_if.done === 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done: got done=1 expected no done");
            end else begin
               s = sb_q.pop_front();
               check_val($sformatf("err_op%0d", s.op), 32'(bus_if.err), 32'(s.err));
               check_val($sformatf("latch_q_op%0d", s.op), 32'(latch_q), 32'(s.q));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int       ph;
      int       nhs;
      logic     cur_op;
      logic     op_now;
      logic [31:0] pat;
      sb_t      s;

      vecs[0] = '{op: 1'b1, f0: 1'b0, exp_err: 1'b0, exp_q: 1'b1};  // set
      vecs[1] = '{op: 1'b0, f0: 1'b0, exp_err: 1'b0, exp_q: 1'b0};  // clear right after
      vecs[2] = '{op: 1'b0, f0: 1'b0, exp_err: 1'b0, exp_q: 1'b0};  // repeated clear
      vecs[3] = '{op: 1'b1, f0: 1'b1, exp_err: 1'b1, exp_q: 1'b1};  // set, q_fb forced 0
      vecs[4] = '{op: 1'b1, f0: 1'b0, exp_err: 1'b0, exp_q: 1'b1};  // next cmd normal
      vecs[5] = '{op: 1'b0, f0: 1'b1, exp_err: 1'b0, exp_q: 1'b0};  // clear, q_fb 0 anyway

      reset            = 1'b1;
      force0           = 1'b0;
      bus_if.req_valid = 1'b0;
      bus_if.req_op    = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("reset_sbar_rbar_rdy_busy_done",
                32'({bus_if.sbar, bus_if.rbar, bus_if.req_ready, bus_if.busy, bus_if.done}),
                32'(5'b11000));
      reset = 1'b0;

      // Idle after reset, latch holds its initial value.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         expect_cycle(0, 1'b0);
      end
      check_val("idle_latch_hold", 32'(latch_q), 32'd0);

      // Table-driven commands, back to back.
      for (int i = 0; i < 6; i++) begin
         run_cmd(vecs[i].op, vecs[i].f0, vecs[i].exp_err, vecs[i].exp_q);
      end

      // req_valid held with a changing op: one command per LAST+1 cycles.
      force0 = 1'b0;
      pat    = 32'h5A5B_A4A5;
      ph     = 0;
      nhs    = 0;
      cur_op = 1'b0;
      for (int c = 0; c < 3 * (LAST + 1); c++) begin
         @(negedge clk);
         expect_cycle(ph, cur_op);
         op_now           = pat[c % 32];
         bus_if.req_valid = 1'b1;
         bus_if.req_op    = op_now;
         if (ph == 0) begin
            cur_op = op_now;
            s.op = op_now; s.err = 1'b0; s.q = op_now;
            sb_q.push_back(s);
            nhs++;
            ph = 1;
         end else begin
            ph = (ph == LAST) ? 0 : ph + 1;
         end
      end
      bus_if.req_valid = 1'b0;
      while (ph != 0) begin
         @(negedge clk);
         expect_cycle(ph, cur_op);
         ph = (ph == LAST) ? 0 : ph + 1;
      end
      check_val("held_valid_handshakes", 32'(nhs), 32'd3);

      // Reset during cycle 2 of a set pulse: truncated, no done.
      @(negedge clk);
      expect_cycle(0, 1'b1);
      bus_if.req_valid = 1'b1;
      bus_if.req_op    = 1'b1;
      @(negedge clk);
      expect_cycle(1, 1'b1);
      bus_if.req_valid = 1'b0;
      @(negedge clk);
      expect_cycle(2, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check_val("midpulse_reset_sbar_rbar_rdy_busy_done",
                32'({bus_if.sbar, bus_if.rbar, bus_if.req_ready, bus_if.busy, bus_if.done}),
                32'(5'b11000));
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         expect_cycle(0, 1'b1);
      end
      run_cmd(1'b0, 1'b0, 1'b0, 1'b0);

      @(negedge clk);
      expect_cycle(0, 1'b0);
      check_val("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
